// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and frame-format helpers for the UART transmit path
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  localparam int BIT_CNT_W = 3;

  // dataLength code 0..3 selects 5..8 data bits
  function automatic logic [3:0] data_bits(input logic [1:0] code);
    return {2'b00, code} + 4'd5;
  endfunction

  function automatic logic [BIT_CNT_W-1:0] data_last_idx(input logic [1:0] code);
    return {1'b0, code} + 3'd4;
  endfunction

  // code 3 is a second encoding of "no parity"
  function automatic logic parity_en(input logic [1:0] code);
    return (code == PARITY_EVEN) || (code == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// rtl/uart_tx_bit_timer.sv - bit-period divider; ticks on the last clock of each bit
module uart_tx_bit_timer #(
  parameter int CLK_DIV_W = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_run,
  input  logic                 i_clr,
  input  logic [CLK_DIV_W-1:0] i_div,
  output logic                 o_tick
);

  logic [CLK_DIV_W-1:0] r_cnt;

  assign o_tick = i_run && (r_cnt == i_div);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CLK_DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit engine: FIFO stream in, framed serial out
// Optional UART_TX_CTS_EN adds io_cts_n flow control gating the next byte fetch.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_DIV_W = 20,
  parameter int DATA_W    = 8
) (
  input  logic                 io_mainClk,
  input  logic                 resetCtrl_systemResetn,
  input  logic                 io_read_valid,
  output logic                 io_read_ready,
  input  logic [DATA_W-1:0]    io_read_payload,
  input  logic [CLK_DIV_W-1:0] io_cfg_clockDivider,
  input  logic [1:0]           io_cfg_dataLength,
  input  logic [1:0]           io_cfg_parity,
  input  logic                 io_cfg_stop,
  output logic                 io_txd,
  output logic                 io_busy
`ifdef UART_TX_CTS_EN
  ,
  input  logic                 io_cts_n
`endif
);

  tx_state_e              r_state;
  logic                   r_txd;
  logic                   r_busy;
  logic                   r_alive;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [BIT_CNT_W-1:0]   r_last_idx;
  logic [DATA_W-1:0]      r_shift;
  logic                   r_par_en;
  logic                   r_par_bit;
  logic                   r_stop;
  logic [CLK_DIV_W-1:0]   r_div;

  logic                   w_tick;
  logic                   w_run;
  logic                   w_last_stop;
  logic                   w_ready;
  logic                   w_fire;
  logic                   w_tx_enable;
  logic [3:0]             w_nbits;
  logic                   w_par_xor;
  logic                   w_par_bit;
  logic [BIT_CNT_W-1:0]   w_stop_last;

`ifdef UART_TX_CTS_EN
  logic [1:0] r_cts_sync;

  always_ff @(posedge io_mainClk or negedge resetCtrl_systemResetn) begin
    if (!resetCtrl_systemResetn) begin
      r_cts_sync <= 2'b11;
    end else begin
      r_cts_sync <= {r_cts_sync[0], io_cts_n};
    end
  end

  assign w_tx_enable = !r_cts_sync[1];
`else
  assign w_tx_enable = 1'b1;
`endif

  assign w_run       = (r_state != ST_IDLE);
  assign w_stop_last = (r_stop == STOP_TWO) ? BIT_CNT_W'(1) : '0;
  assign w_last_stop = (r_state == ST_STOP) && (r_bit_cnt == w_stop_last) && w_tick;
  // r_alive keeps ready low while in reset and for the first clock out of it
  assign w_ready     = ((r_state == ST_IDLE) || w_last_stop) && w_tx_enable && r_alive;
  assign w_fire      = io_read_valid && w_ready;

  assign io_read_ready = w_ready;
  assign io_txd        = r_txd;
  assign io_busy       = r_busy;

  uart_tx_bit_timer #(
    .CLK_DIV_W(CLK_DIV_W)
  ) u_bit_timer (
    .i_clk  (io_mainClk),
    .i_rst_n(resetCtrl_systemResetn),
    .i_run  (w_run),
    .i_clr  (w_fire),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  // Parity is resolved at fire time over only the bits that will be sent
  always_comb begin
    w_nbits   = data_bits(io_cfg_dataLength);
    w_par_xor = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(w_nbits)) begin
        w_par_xor = w_par_xor ^ io_read_payload[i];
      end
    end
    w_par_bit = w_par_xor ^ (io_cfg_parity == PARITY_ODD);
  end

  always_ff @(posedge io_mainClk or negedge resetCtrl_systemResetn) begin
    if (!resetCtrl_systemResetn) begin
      r_state    <= ST_IDLE;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_alive    <= 1'b0;
      r_bit_cnt  <= '0;
      r_last_idx <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop     <= STOP_ONE;
      r_div      <= '0;
    end else begin
      r_alive <= 1'b1;
      if (w_fire) begin
        r_state    <= ST_START;
        r_txd      <= 1'b0;
        r_busy     <= 1'b1;
        r_bit_cnt  <= '0;
        r_shift    <= io_read_payload;
        r_last_idx <= data_last_idx(io_cfg_dataLength);
        r_par_en   <= parity_en(io_cfg_parity);
        r_par_bit  <= w_par_bit;
        r_stop     <= io_cfg_stop;
        r_div      <= io_cfg_clockDivider;
      end else if (w_tick) begin
        case (r_state)
          ST_START: begin
            r_state   <= ST_DATA;
            r_txd     <= r_shift[0];
            r_bit_cnt <= '0;
          end
          ST_DATA: begin
            if (r_bit_cnt == r_last_idx) begin
              r_bit_cnt <= '0;
              if (r_par_en) begin
                r_state <= ST_PARITY;
                r_txd   <= r_par_bit;
              end else begin
                r_state <= ST_STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
              r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
              r_txd     <= r_shift[1];
            end
          end
          ST_PARITY: begin
            r_state   <= ST_STOP;
            r_txd     <= 1'b1;
            r_bit_cnt <= '0;
          end
          ST_STOP: begin
            if (r_bit_cnt == w_stop_last) begin
              r_state   <= ST_IDLE;
              r_txd     <= 1'b1;
              r_busy    <= 1'b0;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

  localparam int CLK_DIV_W = 20;
  localparam int DATA_W    = 8;
  localparam int LIMIT     = 5000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid = 1'b0;
  logic                 ready;
  logic [DATA_W-1:0]    payload = '0;
  logic [CLK_DIV_W-1:0] cfg_div = '0;
  logic [1:0]           cfg_len = 2'd3;
  logic [1:0]           cfg_par = 2'd0;
  logic                 cfg_stop = 1'b0;
  logic                 txd;
  logic                 busy;
`ifdef UART_TX_CTS_EN
  logic                 cts_n = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .CLK_DIV_W(CLK_DIV_W),
    .DATA_W   (DATA_W)
  ) dut (
    .io_mainClk            (clk),
    .resetCtrl_systemResetn(rst_n),
    .io_read_valid         (valid),
    .io_read_ready         (ready),
    .io_read_payload       (payload),
    .io_cfg_clockDivider   (cfg_div),
    .io_cfg_dataLength     (cfg_len),
    .io_cfg_parity         (cfg_par),
    .io_cfg_stop           (cfg_stop),
    .io_txd                (txd),
    .io_busy               (busy)
`ifdef UART_TX_CTS_EN
    ,
    .io_cts_n              (cts_n)
`endif
  );

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          div;
  } frame_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int frames_done = 0;
  int exp_frames = 0;
  int b2b_count = 0;

  frame_t cur;
  bit     mon_active = 0;
  bit     mon_ended;
  int     clk_idx = 0;
  logic   exp_bit;

  function automatic frame_t make_frame(input logic [7:0] data, input logic [1:0] len,
                                        input logic [1:0] par, input logic stop, input int div);
    frame_t f;
    int     n;
    logic   p;
    n = int'(len) + 5;
    f.bits = '0;
    f.bits[0] = 1'b0;
    f.nbits = 1;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[f.nbits] = data[i];
      p = p ^ data[i];
      f.nbits++;
    end
    if (par == 2'd1) begin
      f.bits[f.nbits] = p;
      f.nbits++;
    end else if (par == 2'd2) begin
      f.bits[f.nbits] = ~p;
      f.nbits++;
    end
    for (int i = 0; i < (stop ? 2 : 1); i++) begin
      f.bits[f.nbits] = 1'b1;
      f.nbits++;
    end
    f.div = div;
    return f;
  endfunction

  // Scoreboard monitor: pops one expected frame per fire and checks txd each clock
  always @(negedge clk) begin
    mon_ended = 0;
    if (!rst_n) begin
      mon_active = 0;
      clk_idx = 0;
    end else begin
      if (mon_active) begin
        exp_bit = cur.bits[clk_idx / (cur.div + 1)];
        n_checks++;
        if (txd !== exp_bit) begin
          n_errors++;
          $display("FAIL frame_txd frame=%0d clk=%0d got=%b expected=%b", frames_done, clk_idx, txd, exp_bit);
        end
        n_checks++;
        if (busy !== 1'b1) begin
          n_errors++;
          $display("FAIL frame_busy frame=%0d clk=%0d got=%b expected=1", frames_done, clk_idx, busy);
        end
        clk_idx++;
        if (clk_idx == cur.nbits * (cur.div + 1)) begin
          mon_active = 0;
          frames_done++;
          mon_ended = 1;
        end
      end else begin
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
          n_errors++;
          $display("FAIL idle_line got txd=%b busy=%b expected txd=1 busy=0", txd, busy);
        end
      end
      if (valid && ready) begin
        n_checks++;
        if (mon_active) begin
          n_errors++;
          $display("FAIL early_fire got fire at frame clk %0d expected none", clk_idx);
        end else if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_fire got fire expected none queued");
        end else begin
          cur = exp_q.pop_front();
          mon_active = 1;
          clk_idx = 0;
          if (mon_ended) b2b_count++;
        end
      end
    end
  end

  task automatic wait_fire(output int n, output bit ok);
    n = 0;
    ok = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      n++;
      if (valid && ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL fire_timeout got no fire expected one within %0d clks", LIMIT);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  task automatic set_cfg(input int div, input logic [1:0] len, input logic [1:0] par, input logic stop);
    cfg_div  = CLK_DIV_W'(div);
    cfg_len  = len;
    cfg_par  = par;
    cfg_stop = stop;
  endtask

  task automatic send_byte(input logic [7:0] data, output int busy_clks);
    int n;
    bit ok;
    exp_q.push_back(make_frame(data, cfg_len, cfg_par, cfg_stop, int'(cfg_div)));
    exp_frames++;
    @(posedge clk);
    #1;
    payload = data;
    valid = 1'b1;
    wait_fire(n, ok);
    valid = 1'b0;
    busy_clks = 0;
    if (ok) count_busy(busy_clks);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b1;
    payload = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (txd !== 1'b1) begin n_errors++; $display("FAIL reset_txd got=%b expected=1", txd); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b expected=0", busy); end
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready got=%b expected=0", ready); end
    valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b1) begin n_errors++; $display("FAIL idle_ready got=%b expected=1", ready); end
  endtask

  task automatic test_8n1();
    int n;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    send_byte(8'h55, n);
    n_checks++;
    if (n !== 40) begin n_errors++; $display("FAIL len_8n1 got=%0d clks expected=40", n); end
  endtask

  task automatic test_parity();
    int n;
    set_cfg(0, 2'd3, 2'd1, 1'b0);
    send_byte(8'h07, n);
    n_checks++;
    if (n !== 11) begin n_errors++; $display("FAIL len_even got=%0d expected=11", n); end
    set_cfg(0, 2'd3, 2'd2, 1'b0);
    send_byte(8'h07, n);
    n_checks++;
    if (n !== 11) begin n_errors++; $display("FAIL len_odd got=%0d expected=11", n); end
    set_cfg(0, 2'd0, 2'd3, 1'b0);
    send_byte(8'hE6, n);
    n_checks++;
    if (n !== 7) begin n_errors++; $display("FAIL len_par3_5bit got=%0d expected=7", n); end
  endtask

  task automatic test_two_stop();
    int n;
    set_cfg(1, 2'd2, 2'd0, 1'b1);
    send_byte(8'hFF, n);
    n_checks++;
    if (n !== 20) begin n_errors++; $display("FAIL len_7n2 got=%0d expected=20", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    int b0;
    bit ok;
    set_cfg(2, 2'd3, 2'd0, 1'b0);
    exp_q.push_back(make_frame(8'hA5, cfg_len, cfg_par, cfg_stop, 2));
    exp_q.push_back(make_frame(8'h3C, cfg_len, cfg_par, cfg_stop, 2));
    exp_frames += 2;
    b0 = b2b_count;
    @(posedge clk);
    #1;
    payload = 8'hA5;
    valid = 1'b1;
    wait_fire(n, ok);
    payload = 8'h3C;
    wait_fire(n, ok);
    valid = 1'b0;
    n_checks++;
    if (n !== 30) begin n_errors++; $display("FAIL b2b_ready_clk got=%0d expected=30", n); end
    count_busy(n);
    n_checks++;
    if (n !== 30) begin n_errors++; $display("FAIL b2b_second_len got=%0d expected=30", n); end
    n_checks++;
    if (b2b_count !== b0 + 1) begin n_errors++; $display("FAIL b2b_no_gap got=%0d expected=%0d", b2b_count, b0 + 1); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    bit ok;
    set_cfg(3, 2'd3, 2'd0, 1'b0);
    exp_q.push_back(make_frame(8'h00, cfg_len, cfg_par, cfg_stop, 3));
    @(posedge clk);
    #1;
    payload = 8'h00;
    valid = 1'b1;
    wait_fire(n, ok);
    valid = 1'b0;
    repeat (18) @(posedge clk);
    #2;
    n_checks++;
    if (txd !== 1'b0) begin n_errors++; $display("FAIL pre_abort_txd got=%b expected=0", txd); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (txd !== 1'b1) begin n_errors++; $display("FAIL abort_txd got=%b expected=1", txd); end
    n_checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_state got busy=%b ready=%b expected 0 0", busy, ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || txd !== 1'b1 || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL post_abort_idle got busy=%b txd=%b ready=%b expected 0 1 1", busy, txd, ready);
    end
    send_byte(8'h96, n);
    n_checks++;
    if (n !== 40) begin n_errors++; $display("FAIL post_abort_len got=%0d expected=40", n); end
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts();
    int n;
    bit ok;
    set_cfg(0, 2'd3, 2'd0, 1'b0);
    cts_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(make_frame(8'h5A, cfg_len, cfg_par, cfg_stop, 0));
    exp_frames++;
    payload = 8'h5A;
    valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0 || txd !== 1'b1) begin
        n_errors++;
        $display("FAIL cts_block got ready=%b txd=%b expected 0 1", ready, txd);
      end
    end
    @(posedge clk);
    #1;
    cts_n = 1'b0;
    wait_fire(n, ok);
    valid = 1'b0;
    n_checks++;
    if (n < 2 || n > 3) begin n_errors++; $display("FAIL cts_latency got=%0d expected 2..3", n); end
    repeat (3) @(posedge clk);
    #1;
    cts_n = 1'b1;
    count_busy(n);
    n_checks++;
    if (n !== 7) begin n_errors++; $display("FAIL cts_frame_complete got=%0d expected=7", n); end
    cts_n = 1'b0;
    repeat (3) @(posedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_CTS_EN
    test_cts();
`endif
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() !== 0) begin n_errors++; $display("FAIL queue_drained got=%0d expected=0", exp_q.size()); end
    n_checks++;
    if (frames_done !== exp_frames) begin
      n_errors++;
      $display("FAIL frames_done got=%0d expected=%0d", frames_done, exp_frames);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit engine. It drains bytes from the TX StreamFifo pop side over a valid/ready stream and serializes each byte onto io_txd.
- Frame format: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
- Sits between the TX FIFO and the pad inside the APB UART peripheral. Frame configuration comes from APB control registers.

Parameters:
- CLK_DIV_W, 20, width of the bit-period divider.
- DATA_W, 8, maximum data width; payload width.

Ports:
- io_mainClk  in  1  system clock
- resetCtrl_systemResetn  in  1  reset, asynchronous assert, active-low
- io_read_valid  in  1  byte available (FIFO pop valid)
- io_read_ready  out  1  byte accepted this cycle (FIFO pop ready)
- io_read_payload  in  DATA_W  byte to send
- io_cfg_clockDivider  in  CLK_DIV_W  bit period = value+1 clocks
- io_cfg_dataLength  in  2  0=5, 1=6, 2=7, 3=8 data bits
- io_cfg_parity  in  2  0=none, 1=even, 2=odd, 3=none
- io_cfg_stop  in  1  0=one stop bit, 1=two stop bits
- io_txd  out  1  serial line, idle high
- io_busy  out  1  frame in progress (state != IDLE)

Behaviour:
Reset:
- States are IDLE, START, DATA, PARITY, STOP.
- While resetCtrl_systemResetn=0: state=IDLE, io_txd=1, io_busy=0, io_read_ready=0, bit and divider counters=0.
- Reset asserted mid-frame drives io_txd to 1 immediately (asynchronous). The partial frame is abandoned.
- A byte already popped from the FIFO before reset is lost. This is acceptable.

Handshake:
- io_read_ready = (state==IDLE || lastStopEnd) && txEnable. It depends only on registered state.
- lastStopEnd = state==STOP && final stop bit && divider==cfgDiv.
- txEnable = 1 unless UART_TX_CTS_EN is defined.
- Fire = valid && ready. Payload, dataLength, parity, stop and clockDivider are all latched on fire.
- Config changes mid-frame have no effect until the next fire.

Timing:
- State enters START on the cycle after fire, so io_txd=0 one clock after fire.
- Every bit lasts exactly cfgDiv+1 clocks. The divider counts 0..cfgDiv and clears on each bit change.
- cfgDiv=0 gives 1 clock per bit.
- Back-to-back: fire during lastStopEnd goes STOP->START with no idle gap.

Transitions:
- START -> DATA.
- DATA shifts LSB first and sends dataLength+5 bits, bitCnt 0..N-1. Then goes to PARITY if parity is even/odd, else STOP.
- PARITY sends XOR of the N sent data bits, inverted for odd. Upper unused payload bits are ignored.
- STOP holds io_txd=1 for 1 or 2 bit periods, then goes to IDLE, or to START if a fire occurs.
- No fire in IDLE keeps io_txd=1.

Other rules:
- io_txd is registered. There is no combinational path from inputs to io_txd.
- Divider arithmetic is unsigned CLK_DIV_W bits; compare uses ==, so there is no wrap issue.

Optional Feature:
- Macro UART_TX_CTS_EN.
- Defined:
  - Adds input io_cts_n (1 bit, active-low clear-to-send).
  - Synchronized through 2 flops reset to 1. txEnable = !cts_n_sync.
  - Deasserting CTS never truncates a frame. It only blocks the next fire.
- Undefined:
  - No port is added. txEnable is constant 1.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity codes (PARITY_NONE=0, EVEN=1, ODD=2);
  - stop codes;
  - dataLength-to-bitcount mapping (code+5).
- One natural sub-module is uart_tx_bit_timer: divider counter with clear input and a tick output at count==cfgDiv.

Test Plan:
1. div=3, 8N1, push 0x55 -> txd low 4 clks after fire+1, then 1,0,1,0,1,0,1,0 at 4 clks each, then high 4 clks; frame = 40 clks; busy high throughout.
2. div=0, 8 bits, even parity, 0x07 -> data 1,1,1,0,0,0,0,0, parity=1, 1 stop; odd parity on 0x07 -> parity=0.
3. div=1, 7 bits, 2 stop, none, 0xFF -> 7 ones after start, bit7 ignored, stop high 4 clks; total 20 clks.
4. Two bytes 0xA5,0x3C preloaded, div=2 -> ready pulses at the last clock of the first stop; second start bit directly follows with no idle cycle.
5. Reset asserted during DATA bit 3 of 0x00 -> txd=1 same cycle; after release state IDLE, busy=0, next byte sent correctly.
6. UART_TX_CTS_EN: cts_n=1 with valid high -> ready stays 0 and txd=1; cts_n->0 -> fire 2-3 clks later; cts_n->1 mid-frame -> frame completes.
